// File: rtl/rv_core_pkg.sv
// Shared core types: datapath width, register index and writeback arbitration enums.
package rv_core_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [4:0] reg_idx_t;

  // Which source owns the register file write port in a given cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_MD
  } wb_src_e;

  // Starvation guard for MUL/DIV results waiting behind ALU writebacks.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FORCE
  } arb_state_e;

endpackage

// File: rtl/md_scoreboard.sv
// Pending-result scoreboard for MUL/DIV destinations and the decode hazard stall.
module md_scoreboard
  import rv_core_pkg::*;
#(
  parameter int unsigned NREG = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       id_valid_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic [4:0] id_rd_i,
  input  logic       id_rd_wr_i,
  input  logic       id_is_md_i,
  input  logic       clr_en_i,
  input  logic [4:0] clr_idx_i,
  output logic       id_stall_o
);

  logic [NREG-1:0] pending_q, pending_d;
  logic            issue_md;

  // A bit still set in the cycle it is being cleared keeps stalling; issue waits one cycle.
  assign id_stall_o = id_valid_i & (pending_q[id_rs1_i] | pending_q[id_rs2_i] |
                                    (id_rd_wr_i & pending_q[id_rd_i]));

  assign issue_md = id_valid_i & ~id_stall_o & id_is_md_i & id_rd_wr_i & (id_rd_i != '0);

  // Set on MUL/DIV issue, clear on MUL/DIV writeback; x0 never pending.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) begin
      pending_d[clr_idx_i] = 1'b0;
    end
    if (issue_md) begin
      pending_d[id_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending vector register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register file write-port arbiter between ALU/load writeback and the MUL/DIV unit.
// ALU has priority; rf_* outputs are registered (one cycle after acceptance).
// Define WB_STARVE_GUARD_EN to enable the starvation guard FSM and wb_bubble_req_o;
// without it MUL/DIV simply waits for an ALU-free cycle.
module regfile_wb_arbiter
  import rv_core_pkg::*;
#(
  parameter int unsigned XLEN       = rv_core_pkg::XLEN,
  parameter int unsigned NREG       = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [4:0]      id_rs1_i,
  input  logic [4:0]      id_rs2_i,
  input  logic [4:0]      id_rd_i,
  input  logic            id_rd_wr_i,
  input  logic            id_is_md_i,
  output logic            id_stall_o,
  input  logic            alu_valid_i,
  input  logic [4:0]      alu_rd_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            md_valid_i,
  input  logic [4:0]      md_rd_i,
  input  logic [XLEN-1:0] md_data_i,
  output logic            md_ready_o,
  output logic            wb_bubble_req_o,
  output logic            rf_wr_en_o,
  output logic [4:0]      rf_rd_o,
  output logic [XLEN-1:0] rf_wdata_o
);

  if (STARVE_LIM < 1 || STARVE_LIM > 15) begin : g_lim_check
    $error("STARVE_LIM must be in 1..15");
  end

  wb_src_e         src_d, src_q;
  logic            rf_wr_en_d, rf_wr_en_q;
  reg_idx_t        rf_rd_d, rf_rd_q;
  logic [XLEN-1:0] rf_wdata_d, rf_wdata_q;
  logic            force_md;

`ifdef WB_STARVE_GUARD_EN
  localparam logic [3:0] LimW = 4'(STARVE_LIM);

  arb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       md_waiting;

  assign force_md   = (state_q == FORCE);
  assign md_ready_o = ~rst_i & (force_md | ~alu_valid_i);
  assign md_waiting = md_valid_i & ~md_ready_o;

  // FSM state and wait counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Count consecutive refused cycles; force acceptance once the limit is reached.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, WAIT: begin
        if (md_waiting) begin
          cnt_d   = cnt_q + 4'd1;
          state_d = (cnt_d == LimW) ? FORCE : WAIT;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      FORCE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Bubble request in the cycle that reaches the limit, so the next cycle is ALU-free.
  always_comb begin
    wb_bubble_req_o = ~rst_i & md_waiting & (state_q != FORCE) & ((cnt_q + 4'd1) == LimW);
  end

`ifndef SYNTHESIS
  // An ALU write in FORCE is dropped: upstream ignored the bubble request.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(force_md && alu_valid_i))
        else $error("ALU writeback dropped during forced MUL/DIV writeback");
    end
  end
`endif
`else
  assign force_md        = 1'b0;
  assign md_ready_o      = ~rst_i & ~alu_valid_i;
  assign wb_bubble_req_o = 1'b0;
`endif

  // Pick the write source; MUL/DIV only wins when ready, i.e. ALU idle or forced.
  always_comb begin
    src_d      = WB_NONE;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (md_valid_i && md_ready_o) begin
      src_d      = WB_MD;
      rf_rd_d    = md_rd_i;
      rf_wdata_d = md_data_i;
    end else if (alu_valid_i && !force_md) begin
      src_d      = WB_ALU;
      rf_rd_d    = alu_rd_i;
      rf_wdata_d = alu_data_i;
    end
    rf_wr_en_d = (src_d != WB_NONE) && (rf_rd_d != '0);
  end

  // Registered write port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q      <= WB_NONE;
      rf_wr_en_q <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      src_q      <= src_d;
      rf_wr_en_q <= rf_wr_en_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wr_en_o = rf_wr_en_q;
  assign rf_rd_o    = rf_rd_q;
  assign rf_wdata_o = rf_wdata_q;

  md_scoreboard #(
    .NREG(NREG)
  ) u_md_scoreboard (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .id_valid_i(id_valid_i),
    .id_rs1_i  (id_rs1_i),
    .id_rs2_i  (id_rs2_i),
    .id_rd_i   (id_rd_i),
    .id_rd_wr_i(id_rd_wr_i),
    .id_is_md_i(id_is_md_i),
    .clr_en_i  (rf_wr_en_q && (src_q == WB_MD)),
    .clr_idx_i (rf_rd_q),
    .id_stall_o(id_stall_o)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a cycle-level reference model built from the arbitration rules.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned LIM  = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_rd_wr, id_is_md, id_stall;
  logic [4:0]      id_rs1, id_rs2, id_rd;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            md_valid, md_ready, wb_bubble_req, rf_wr_en;
  logic [4:0]      md_rd, rf_rd;
  logic [XLEN-1:0] md_data, rf_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .XLEN      (XLEN),
    .NREG      (32),
    .STARVE_LIM(LIM)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_valid_i     (id_valid),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_rd_i        (id_rd),
    .id_rd_wr_i     (id_rd_wr),
    .id_is_md_i     (id_is_md),
    .id_stall_o     (id_stall),
    .alu_valid_i    (alu_valid),
    .alu_rd_i       (alu_rd),
    .alu_data_i     (alu_data),
    .md_valid_i     (md_valid),
    .md_rd_i        (md_rd),
    .md_data_i      (md_data),
    .md_ready_o     (md_ready),
    .wb_bubble_req_o(wb_bubble_req),
    .rf_wr_en_o     (rf_wr_en),
    .rf_rd_o        (rf_rd),
    .rf_wdata_o     (rf_wdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rd_wr = 0; id_is_md = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    md_valid = 0; md_rd = 0; md_data = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic issue_md(input logic [4:0] rd);
    id_valid = 1; id_is_md = 1; id_rd_wr = 1; id_rd = rd; id_rs1 = 0; id_rs2 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en got %b want 0", rf_wr_en); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL rst_rd got %0d want 0", rf_rd); end
    // build up a waiting MUL/DIV result with pending[7] set
    issue_md(5'd7);
    tick();
    idle_inputs();
    md_valid = 1; md_rd = 5'd7; md_data = 32'hDEAD_0007;
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h77;
    tick();
    tick();
    checks++; if (rf_rd !== 5'd2) begin errors++; $display("FAIL midwait_alu_rd got %0d want 2", rf_rd); end
    id_valid = 1; id_rs1 = 5'd7;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL midwait_stall got %b want 1", id_stall); end
    rst = 1; alu_valid = 0;
    #1;
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL rst_md_ready got %b want 0", md_ready); end
    checks++; if (wb_bubble_req !== 1'b0) begin errors++; $display("FAIL rst_bubble got %b want 0", wb_bubble_req); end
    tick();
    rst = 0; md_valid = 0;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL rst2_wr_en got %b want 0", rf_wr_en); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL rst2_rd got %0d want 0", rf_rd); end
    checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL rst2_wdata got %h want 0", rf_wdata); end
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL rst2_stall_rs1_7 got %b want 0", id_stall); end
    // counter restarted: no early bubble while waiting again
    id_valid = 0; md_valid = 1; alu_valid = 1; alu_rd = 5'd3;
    for (int i = 0; i < int'(LIM) - 1; i++) begin
      #1;
      checks++; if (wb_bubble_req !== 1'b0) begin errors++; $display("FAIL rst_fsm_idle cyc %0d bubble got %b want 0", i, wb_bubble_req); end
      tick();
    end
  endtask

  task automatic test_mul_dependent();
    do_reset();
    issue_md(5'd5);
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL dep_issue_stall got %b want 0", id_stall); end
    tick();
    id_is_md = 0; id_rd_wr = 0; id_rd = 0; id_rs1 = 5'd5;
    md_valid = 1; md_rd = 5'd5; md_data = 32'h0000_0042;
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL dep_raw_stall got %b want 1", id_stall); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL dep_md_ready got %b want 1", md_ready); end
    tick();
    md_valid = 0;
    checks++; if (rf_wr_en !== 1'b1) begin errors++; $display("FAIL dep_wr_en got %b want 1", rf_wr_en); end
    checks++; if (rf_rd !== 5'd5) begin errors++; $display("FAIL dep_rd got %0d want 5", rf_rd); end
    checks++; if (rf_wdata !== 32'h42) begin errors++; $display("FAIL dep_wdata got %h want 42", rf_wdata); end
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL dep_clear_cycle_stall got %b want 1", id_stall); end
    tick();
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL dep_after_wr_en got %b want 0", rf_wr_en); end
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL dep_after_stall got %b want 0", id_stall); end
  endtask

  task automatic test_collision();
    do_reset();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
    md_valid = 1; md_rd = 5'd9; md_data = 32'h99;
    #1;
    checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL col_ready0 got %b want 0", md_ready); end
    tick();
    alu_valid = 0;
    checks++; if (rf_wr_en !== 1'b1 || rf_rd !== 5'd3 || rf_wdata !== 32'h11) begin
      errors++; $display("FAIL col_alu_first got en=%b rd=%0d d=%h want en=1 rd=3 d=11", rf_wr_en, rf_rd, rf_wdata);
    end
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL col_ready1 got %b want 1", md_ready); end
    tick();
    md_valid = 0;
    checks++; if (rf_wr_en !== 1'b1 || rf_rd !== 5'd9 || rf_wdata !== 32'h99) begin
      errors++; $display("FAIL col_md_second got en=%b rd=%0d d=%h want en=1 rd=9 d=99", rf_wr_en, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_starvation();
    do_reset();
    md_valid = 1; md_rd = 5'd4; md_data = 32'h0000_ABCD;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h100;
`ifdef WB_STARVE_GUARD_EN
    for (int i = 0; i < int'(LIM); i++) begin
      #1;
      checks++; if (wb_bubble_req !== (i == int'(LIM) - 1)) begin
        errors++; $display("FAIL starve_bubble cyc %0d got %b want %b", i, wb_bubble_req, i == int'(LIM) - 1);
      end
      checks++; if (md_ready !== 1'b0) begin errors++; $display("FAIL starve_wait_ready cyc %0d got %b want 0", i, md_ready); end
      tick();
      alu_rd = 5'(1 + (i % 3)); alu_data = 32'h100 + 32'(i);
    end
    alu_valid = 0;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL starve_force_ready got %b want 1", md_ready); end
    checks++; if (wb_bubble_req !== 1'b0) begin errors++; $display("FAIL starve_force_bubble got %b want 0", wb_bubble_req); end
`else
    for (int i = 0; i < 3 * int'(LIM); i++) begin
      #1;
      checks++; if (md_ready !== 1'b0 || wb_bubble_req !== 1'b0) begin
        errors++; $display("FAIL starve_off cyc %0d got rdy=%b bub=%b want 0 0", i, md_ready, wb_bubble_req);
      end
      tick();
    end
    alu_valid = 0;
`endif
    tick();
    md_valid = 0;
    checks++; if (rf_wr_en !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'hABCD) begin
      errors++; $display("FAIL starve_md_write got en=%b rd=%0d d=%h want en=1 rd=4 d=abcd", rf_wr_en, rf_rd, rf_wdata);
    end
  endtask

  task automatic test_x0();
    do_reset();
    issue_md(5'd0);
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL x0_issue_stall got %b want 0", id_stall); end
    tick();
    id_is_md = 0;
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h55;
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL x0_pending_stall got %b want 0", id_stall); end
    tick();
    alu_valid = 0; id_valid = 0;
    checks++; if (rf_wr_en !== 1'b0) begin errors++; $display("FAIL x0_alu_wr_en got %b want 0", rf_wr_en); end
  endtask

  task automatic test_waw();
    do_reset();
    issue_md(5'd12);
    tick();
    id_is_md = 0; id_rd_wr = 1; id_rd = 5'd12; id_rs1 = 5'd1; id_rs2 = 5'd2;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL waw_hold cyc %0d got %b want 1", i, id_stall); end
      tick();
    end
    md_valid = 1; md_rd = 5'd12; md_data = 32'h00C0_FFEE;
    tick();
    md_valid = 0;
    checks++; if (rf_wr_en !== 1'b1 || rf_rd !== 5'd12) begin
      errors++; $display("FAIL waw_md_write got en=%b rd=%0d want en=1 rd=12", rf_wr_en, rf_rd);
    end
    #1;
    checks++; if (id_stall !== 1'b1) begin errors++; $display("FAIL waw_clear_cycle got %b want 1", id_stall); end
    tick();
    #1;
    checks++; if (id_stall !== 1'b0) begin errors++; $display("FAIL waw_released got %b want 0", id_stall); end
  endtask

  task automatic test_random();
    bit [31:0]       pend = '0;
    int              waited = 0;
    bit              forced = 0, bub_prev = 0;
    bit              exp_ready, exp_bub, exp_stall, waiting, md_acc;
    bit              e_en = 0, e_md = 0;
    logic [4:0]      e_rd = '0;
    logic [XLEN-1:0] e_data = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      id_valid = 1'($urandom_range(0, 1));
      id_rs1   = 5'($urandom_range(0, 7));
      id_rs2   = 5'($urandom_range(0, 7));
      id_rd    = 5'($urandom_range(0, 7));
      id_rd_wr = ($urandom_range(0, 3) != 0);
      id_is_md = 1'($urandom_range(0, 1));
      alu_valid = bub_prev ? 1'b0 : ($urandom_range(0, 3) != 0);
      alu_rd   = 5'($urandom_range(0, 7));
      alu_data = $urandom();
      if (!md_valid) begin
        md_valid = ($urandom_range(0, 2) == 0);
        md_rd    = 5'($urandom_range(0, 7));
        md_data  = $urandom();
      end
      // reference: ALU first unless the guard has forced a MUL/DIV slot
      exp_ready = (GUARD && forced) || !alu_valid;
      waiting   = md_valid && !exp_ready;
      exp_bub   = GUARD && waiting && (waited + 1 == int'(LIM));
      exp_stall = id_valid && (pend[id_rs1] || pend[id_rs2] || (id_rd_wr && pend[id_rd]));
      #1;
      checks++; if (id_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc %0d got %b want %b", c, id_stall, exp_stall); end
      checks++; if (md_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready cyc %0d got %b want %b", c, md_ready, exp_ready); end
      checks++; if (wb_bubble_req !== exp_bub) begin errors++; $display("FAIL rnd_bubble cyc %0d got %b want %b", c, wb_bubble_req, exp_bub); end
      md_acc = md_valid && exp_ready;
      if (e_en && e_md) pend[e_rd] = 1'b0;
      if (id_valid && !exp_stall && id_is_md && id_rd_wr && id_rd != 0) pend[id_rd] = 1'b1;
      if (md_acc) begin
        e_md = 1; e_rd = md_rd; e_data = md_data; e_en = (md_rd != 0);
      end else if (alu_valid) begin
        e_md = 0; e_rd = alu_rd; e_data = alu_data; e_en = (alu_rd != 0);
      end else begin
        e_md = 0; e_en = 0;
      end
      if (forced) begin
        forced = 0; waited = 0;
      end else if (waiting) begin
        waited++;
        if (waited == int'(LIM)) begin forced = 1; waited = 0; end
      end else begin
        waited = 0;
      end
      bub_prev = exp_bub;
      tick();
      checks++; if (rf_wr_en !== e_en || rf_rd !== e_rd || rf_wdata !== e_data) begin
        errors++;
        $display("FAIL rnd_rf cyc %0d got en=%b rd=%0d d=%h want en=%b rd=%0d d=%h",
                 c, rf_wr_en, rf_rd, rf_wdata, e_en, e_rd, e_data);
      end
      if (md_acc) md_valid = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_mul_dependent();
    test_collision();
    test_starvation();
    test_x0();
    test_waw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32-entry register file used by the decode stage.
- Arbitrates that port between the in-order ALU/load writeback and the long-latency MUL/DIV unit.
- Keeps a scoreboard of registers with pending MUL/DIV results and stalls decode on RAW/WAW hazards.
- A starvation guard bounds how long a MUL/DIV result can wait behind continuous ALU writebacks.

Parameters:
- XLEN, 32, data width of register file and writeback paths
- NREG, 32, number of architectural registers; index width is $clog2(NREG)
- STARVE_LIM, 4, consecutive cycles a MUL/DIV result may wait before a bubble is requested (range 1..15)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1  in  5  source register 1 index
- id_rs2  in  5  source register 2 index
- id_rd  in  5  destination register index
- id_rd_wr  in  1  instruction writes rd
- id_is_md  in  1  instruction issues to MUL/DIV unit
- id_stall  out  1  hold decode; instruction not issued this cycle
- alu_valid  in  1  ALU/load writeback request; cannot be back-pressured
- alu_rd  in  5  ALU writeback destination
- alu_data  in  XLEN  ALU writeback data
- md_valid  in  1  MUL/DIV result available; held stable until accepted
- md_rd  in  5  MUL/DIV destination
- md_data  in  XLEN  MUL/DIV result
- md_ready  out  1  MUL/DIV result accepted this cycle when md_valid & md_ready
- wb_bubble_req  out  1  asks upstream to insert one bubble: alu_valid must be 0 in the following cycle
- rf_wr_en  out  1  register file write enable
- rf_rd  out  5  register file write index
- rf_wdata  out  XLEN  register file write data

Behaviour:
- Reset (rst=1 at edge):
  - all pending bits cleared
  - rf_wr_en=0, rf_rd=0, rf_wdata=0
  - wb_bubble_req=0
  - FSM to IDLE, starvation counter to 0
  - md_ready=0 while rst=1
  - An in-flight MUL/DIV handshake is dropped; MUL/DIV unit is reset alongside.
- Arbitration is combinational; rf_* outputs are registered, so there is 1-cycle latency from acceptance to rf_wr_en.
- ALU has priority: md_ready = !alu_valid (with the guard disabled, or when not in FORCE).
- Accepted source drives rf_* next cycle. With neither source accepted, rf_wr_en=0; rf_rd/rf_wdata hold their previous values.
- Any accepted write with rd=0 produces rf_wr_en=0 (x0 never written).
- Scoreboard: pending[NREG], bit 0 hardwired 0.
  - Set on issue: id_valid & !id_stall & id_is_md & id_rd_wr & id_rd!=0.
  - Cleared in the cycle rf_wr_en=1 with rf_rd equal to that index and the source being MUL/DIV; cleared on that edge.
  - Issue-set and writeback-clear cannot target the same index in one cycle, because WAW stall forbids it.
- id_stall = id_valid & (pending[id_rs1] | pending[id_rs2] | (id_rd_wr & pending[id_rd])).
  - A bit being cleared this cycle still stalls; issue proceeds the next cycle.
- Starvation FSM, states IDLE, WAIT, FORCE:
  - IDLE -> WAIT when md_valid & !md_ready; counter=1.
  - WAIT: counter increments each cycle md_valid & !md_ready. Goes to IDLE when accepted.
  - WAIT -> FORCE when counter==STARVE_LIM; wb_bubble_req=1 for exactly that one cycle.
  - FORCE: md_ready=1 regardless of alu_valid. Upstream guarantees alu_valid=0; if alu_valid=1 anyway, MUL/DIV still wins and the ALU write is lost (assertion fires). FORCE -> IDLE next cycle.

Optional Feature:
- Macro WB_STARVE_GUARD_EN.
- Defined: starvation FSM and wb_bubble_req behave as above.
- Undefined: no FSM or counter; wb_bubble_req tied 0; md_ready = !alu_valid always, so MUL/DIV may wait indefinitely.

Decomposition:
- Shared package rv_core_pkg:
  - XLEN constant
  - reg_idx_t (logic [4:0])
  - wb_src_e {WB_NONE, WB_ALU, WB_MD}
  - arb_state_e {IDLE, WAIT, FORCE}
- One sub-module, md_scoreboard: pending vector, set/clear logic, hazard compare producing id_stall.
- Arbitration and FSM stay in the top.

Test Plan:
- Reset mid-wait: md_valid=1 waiting in WAIT, pending[7]=1, assert rst one cycle -> next cycle pending all 0, rf_wr_en=0, FSM IDLE, id_stall=0 for rs1=7.
- MUL issue then dependent: issue MUL rd=5; next cycle id_valid rs1=5 -> id_stall=1. md_valid rd=5 data=0x0000_0042 accepted -> rf_wr_en=1, rf_rd=5, rf_wdata=0x42 next cycle, and id_stall=1 in that cycle. id_stall=0 the cycle after.
- Collision: alu_valid rd=3 data=0x11 and md_valid rd=9 same cycle -> ALU written first (rf_rd=3); md_ready=0, then 1 next cycle; rf_rd=9 one cycle later.
- Starvation (STARVE_LIM=4, guard on): alu_valid=1 continuously, md_valid=1 -> wb_bubble_req=1 exactly once, on the 4th waiting cycle. Next cycle md_ready=1, MUL/DIV written. With the macro undefined, md_ready stays 0 throughout.
- x0: MUL rd=0 issue -> pending unchanged, no stall. ALU write rd=0 -> rf_wr_en=0.
- WAW: pending[12]=1, id_valid id_rd=12 id_rd_wr=1 (ALU op) -> id_stall=1 until the MUL/DIV write to 12 completes.
